siso_shift_ext: RTL and testbench

Parametrised universal shift register with per-stage valid tracking. DEPTH stages of WIDTH bits each, selectable hold, shift-right, shift-left and parallel-load modes, with registered serial outputs at both ends. This is the general successor to the single-bit serial-in/serial-out register, used wherever the design serialises or deserialises multi-bit words and needs to know which stages hold real data.

---
 rtl/siso_shift_ext.sv | 106 ++++++++++
 tb/tb_siso_shift_ext.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_ext.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift-right, shift-left and
// parallel-load modes, per-stage valid tracking and registered serial outputs at both ends.
module siso_shift_ext #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [WIDTH*DEPTH-1:0] pin,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic                   sout_vld,
  output logic [CW-1:0]          cnt,
  output logic                   full,
  output logic                   empty
);

  typedef enum logic [1:0] {
    ModeHold  = 2'b00,
    ModeRight = 2'b01,
    ModeLeft  = 2'b10,
    ModeLoad  = 2'b11
  } mode_e;

  logic [DEPTH-1:0][WIDTH-1:0] r_stage, w_stage_d;
  logic [DEPTH-1:0]            r_vld, w_vld_d;
  logic [WIDTH-1:0]            r_sout_r, w_sout_r_d;
  logic [WIDTH-1:0]            r_sout_l, w_sout_l_d;
  logic                        r_sout_vld, w_sout_vld_d;
  logic [CW-1:0]               w_cnt;

  always_comb begin
    w_stage_d    = r_stage;
    w_vld_d      = r_vld;
    w_sout_r_d   = r_sout_r;
    w_sout_l_d   = r_sout_l;
    w_sout_vld_d = 1'b0;
    if (flush) begin
      w_stage_d  = '0;
      w_vld_d    = '0;
      w_sout_r_d = '0;
      w_sout_l_d = '0;
    end else if (en) begin
      unique case (mode_e'(mode))
        ModeHold: ;
        ModeRight: begin
          w_stage_d    = {sin_r, r_stage[DEPTH-1:1]};
          w_vld_d      = {1'b1, r_vld[DEPTH-1:1]};
          w_sout_r_d   = r_stage[0];
          w_sout_vld_d = r_vld[0];
        end
        ModeLeft: begin
          w_stage_d    = {r_stage[DEPTH-2:0], sin_l};
          w_vld_d      = {r_vld[DEPTH-2:0], 1'b1};
          w_sout_l_d   = r_stage[DEPTH-1];
          w_sout_vld_d = r_vld[DEPTH-1];
        end
        ModeLoad: begin
          w_stage_d = pin;
          w_vld_d   = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_stage    <= '0;
      r_vld      <= '0;
      r_sout_r   <= '0;
      r_sout_l   <= '0;
      r_sout_vld <= 1'b0;
    end else begin
      r_stage    <= w_stage_d;
      r_vld      <= w_vld_d;
      r_sout_r   <= w_sout_r_d;
      r_sout_l   <= w_sout_l_d;
      r_sout_vld <= w_sout_vld_d;
    end
  end

  // Valid mask may be non-contiguous after mixed shifts, so count every bit.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CW'(r_vld[i]);
    end
  end

  assign pout     = r_stage;
  assign sout_r   = r_sout_r;
  assign sout_l   = r_sout_l;
  assign sout_vld = r_sout_vld;
  assign cnt      = w_cnt;
  assign full     = (w_cnt == CW'(DEPTH));
  assign empty    = (w_cnt == '0);

endmodule

// File: tb/tb_siso_shift_ext.sv
// Scoreboard bench for siso_shift_ext: a 4x4 and a 16x8 instance driven against a
// behavioural model; expected observations are queued and checked by an independent monitor.
module tb_siso_shift_ext;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  logic       t_en[2];
  logic       t_flush[2];
  logic [1:0] t_mode[2];
  logic [7:0] t_sin_r[2];
  logic [7:0] t_sin_l[2];
  logic [7:0] t_pin[2][16];

  logic [15:0]  a_pin, a_pout;
  logic [3:0]   a_sout_r, a_sout_l;
  logic         a_sout_vld, a_full, a_empty;
  logic [2:0]   a_cnt;
  logic [127:0] b_pin, b_pout;
  logic [7:0]   b_sout_r, b_sout_l;
  logic         b_sout_vld, b_full, b_empty;
  logic [4:0]   b_cnt;

  always_comb begin
    a_pin = '0;
    b_pin = '0;
    for (int i = 0; i < 4; i++) a_pin[i*4 +: 4] = t_pin[0][i][3:0];
    for (int i = 0; i < 16; i++) b_pin[i*8 +: 8] = t_pin[1][i];
  end

  siso_shift_ext #(.WIDTH(4), .DEPTH(4)) u_dut_a (
    .clk(clk), .clr_n(clr_n), .en(t_en[0]), .flush(t_flush[0]), .mode(t_mode[0]),
    .sin_r(t_sin_r[0][3:0]), .sin_l(t_sin_l[0][3:0]), .pin(a_pin), .pout(a_pout),
    .sout_r(a_sout_r), .sout_l(a_sout_l), .sout_vld(a_sout_vld), .cnt(a_cnt),
    .full(a_full), .empty(a_empty)
  );

  siso_shift_ext #(.WIDTH(8), .DEPTH(16)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .en(t_en[1]), .flush(t_flush[1]), .mode(t_mode[1]),
    .sin_r(t_sin_r[1]), .sin_l(t_sin_l[1]), .pin(b_pin), .pout(b_pout),
    .sout_r(b_sout_r), .sout_l(b_sout_l), .sout_vld(b_sout_vld), .cnt(b_cnt),
    .full(b_full), .empty(b_empty)
  );

  // Behavioural model: an array of words per instance plus the serial output registers.
  int         dep[2] = '{4, 16};
  int         wid[2] = '{4, 8};
  logic [7:0] m_stage[2][16];
  logic       m_vld[2][16];
  logic [7:0] m_sr[2], m_sl[2];
  logic       m_sv[2];

  typedef struct {
    logic [127:0] pout;
    logic [7:0]   sr;
    logic [7:0]   sl;
    logic         sv;
    int           cnt;
  } obs_t;
  typedef struct {
    bit         left;
    logic [7:0] w;
  } ser_t;

  obs_t eq0[$], eq1[$];
  ser_t sq0[$], sq1[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 16; i++) begin
      m_stage[k][i] = '0;
      m_vld[k][i]   = 1'b0;
    end
    m_sr[k] = '0;
    m_sl[k] = '0;
    m_sv[k] = 1'b0;
  endtask

  task automatic push_ser(input int k, input bit left, input logic [7:0] w);
    ser_t s;
    s.left = left;
    s.w    = w;
    if (k == 0) sq0.push_back(s);
    else sq1.push_back(s);
  endtask

  task automatic model_edge(input int k);
    logic [7:0] msk;
    int d;
    d   = dep[k];
    msk = (wid[k] == 8) ? 8'hFF : 8'h0F;
    if (!clr_n || t_flush[k]) begin
      model_clear(k);
    end else if (!t_en[k] || t_mode[k] == 2'd0) begin
      m_sv[k] = 1'b0;
    end else if (t_mode[k] == 2'd1) begin
      m_sr[k] = m_stage[k][0];
      m_sv[k] = m_vld[k][0];
      for (int i = 0; i < d - 1; i++) begin
        m_stage[k][i] = m_stage[k][i+1];
        m_vld[k][i]   = m_vld[k][i+1];
      end
      m_stage[k][d-1] = t_sin_r[k] & msk;
      m_vld[k][d-1]   = 1'b1;
      if (m_sv[k]) push_ser(k, 1'b0, m_sr[k]);
    end else if (t_mode[k] == 2'd2) begin
      m_sl[k] = m_stage[k][d-1];
      m_sv[k] = m_vld[k][d-1];
      for (int i = d - 1; i > 0; i--) begin
        m_stage[k][i] = m_stage[k][i-1];
        m_vld[k][i]   = m_vld[k][i-1];
      end
      m_stage[k][0] = t_sin_l[k] & msk;
      m_vld[k][0]   = 1'b1;
      if (m_sv[k]) push_ser(k, 1'b1, m_sl[k]);
    end else begin
      for (int i = 0; i < d; i++) begin
        m_stage[k][i] = t_pin[k][i] & msk;
        m_vld[k][i]   = 1'b1;
      end
      m_sv[k] = 1'b0;
    end
  endtask

  function automatic obs_t model_obs(input int k);
    obs_t o;
    o.pout = '0;
    o.cnt  = 0;
    for (int i = 0; i < dep[k]; i++) begin
      o.pout = o.pout | (128'(m_stage[k][i]) << (i * wid[k]));
      if (m_vld[k][i]) o.cnt++;
    end
    o.sr = m_sr[k];
    o.sl = m_sl[k];
    o.sv = m_sv[k];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    eq0.push_back(model_obs(0));
    eq1.push_back(model_obs(1));
    @(negedge clk);
    #1;
  endtask

  task automatic cmp_obs(input int k, input obs_t e);
    logic [127:0] p;
    logic [7:0]   sr, sl;
    logic         sv, fu, em;
    int           c;
    string        t;
    if (k == 0) begin
      p = 128'(a_pout); sr = 8'(a_sout_r); sl = 8'(a_sout_l); sv = a_sout_vld;
      c = int'(a_cnt); fu = a_full; em = a_empty; t = "a";
    end else begin
      p = b_pout; sr = b_sout_r; sl = b_sout_l; sv = b_sout_vld;
      c = int'(b_cnt); fu = b_full; em = b_empty; t = "b";
    end
    check({t, ".pout"}, p, e.pout);
    check({t, ".sout_r"}, 128'(sr), 128'(e.sr));
    check({t, ".sout_l"}, 128'(sl), 128'(e.sl));
    check({t, ".sout_vld"}, 128'(sv), 128'(e.sv));
    check({t, ".cnt"}, 128'(c), 128'(e.cnt));
    check({t, ".full"}, 128'(fu), 128'(e.cnt == dep[k]));
    check({t, ".empty"}, 128'(em), 128'(e.cnt == 0));
    check({t, ".cnt_bound"}, 128'(c <= dep[k]), 128'(1));
  endtask

  task automatic cmp_ser(input int k);
    ser_t s;
    logic [7:0] w;
    if (k == 0 ? (sq0.size() == 0) : (sq1.size() == 0)) begin
      check(k == 0 ? "a.ser_unexpected" : "b.ser_unexpected", 128'(1), 128'(0));
    end else begin
      s = (k == 0) ? sq0.pop_front() : sq1.pop_front();
      if (k == 0) w = s.left ? 8'(a_sout_l) : 8'(a_sout_r);
      else w = s.left ? b_sout_l : b_sout_r;
      check(k == 0 ? "a.ser_word" : "b.ser_word", 128'(w), 128'(s.w));
    end
  endtask

  // Monitor: decoupled from stimulus, drains whatever the scoreboard holds each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (eq0.size() > 0) cmp_obs(0, eq0.pop_front());
      if (eq1.size() > 0) cmp_obs(1, eq1.pop_front());
      if (a_sout_vld === 1'b1) cmp_ser(0);
      if (b_sout_vld === 1'b1) cmp_ser(1);
    end
  end

  task automatic check_reset_now();
    check("rst.a.pout", 128'(a_pout), 0);
    check("rst.a.sout_r", 128'(a_sout_r), 0);
    check("rst.a.sout_l", 128'(a_sout_l), 0);
    check("rst.a.sout_vld", 128'(a_sout_vld), 0);
    check("rst.a.cnt", 128'(a_cnt), 0);
    check("rst.a.full", 128'(a_full), 0);
    check("rst.a.empty", 128'(a_empty), 1);
    check("rst.b.pout", b_pout, 0);
    check("rst.b.sout_r", 128'(b_sout_r), 0);
    check("rst.b.sout_l", 128'(b_sout_l), 0);
    check("rst.b.sout_vld", 128'(b_sout_vld), 0);
    check("rst.b.cnt", 128'(b_cnt), 0);
    check("rst.b.full", 128'(b_full), 0);
    check("rst.b.empty", 128'(b_empty), 1);
  endtask

  task automatic rand_in(input int k);
    t_en[k]    = ($urandom_range(0, 7) != 0);
    t_flush[k] = ($urandom_range(0, 15) == 0);
    t_mode[k]  = 2'($urandom_range(0, 3));
    t_sin_r[k] = 8'($urandom);
    t_sin_l[k] = 8'($urandom);
    for (int i = 0; i < 16; i++) t_pin[k][i] = 8'($urandom);
  endtask

  task automatic set_op(input int k, input logic [1:0] m);
    rand_in(k);
    t_en[k]    = 1'b1;
    t_flush[k] = 1'b0;
    t_mode[k]  = m;
  endtask

  task automatic set_idle(input int k);
    rand_in(k);
    t_en[k]    = 1'b0;
    t_flush[k] = 1'b0;
  endtask

  task automatic assert_reset();
    clr_n = 1'b0;
    #1;
    check_reset_now();
    model_clear(0);
    model_clear(1);
    eq0.delete(); eq1.delete(); sq0.delete(); sq1.delete();
  endtask

  logic [3:0] pat[8] = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] ld[4]  = '{4'h3, 4'hC, 4'h5, 4'hA};

  initial begin
    clr_n = 1'b1;
    rand_in(0);
    rand_in(1);
    #1;
    assert_reset();
    repeat (3) begin
      rand_in(0);
      rand_in(1);
      tick();
    end
    clr_n = 1'b1;
    repeat (3) begin
      set_idle(0);
      set_idle(1);
      tick();
    end

    // Serial 1,0,1,1 then zeros on the 4-stage instance.
    for (int i = 0; i < 8; i++) begin
      set_op(0, 2'd1);
      t_sin_r[0] = 8'(pat[i]);
      set_idle(1);
      tick();
    end

    // Load A5C3 and shift it out to the left.
    set_op(0, 2'd3);
    for (int i = 0; i < 4; i++) t_pin[0][i] = 8'(ld[i]);
    set_idle(1);
    tick();
    repeat (4) begin
      set_op(0, 2'd2);
      set_idle(1);
      tick();
    end

    // Flush beats a simultaneous load.
    set_op(0, 2'd3);
    t_flush[0] = 1'b1;
    set_op(1, 2'd3);
    t_flush[1] = 1'b1;
    tick();

    // Mixed directions from empty leave mask 1001.
    set_op(0, 2'd1); set_idle(1); tick();
    set_op(0, 2'd1); set_idle(1); tick();
    set_op(0, 2'd2); set_idle(1); tick();
    check("mixed.cnt", 128'(a_cnt), 2);
    check("mixed.full", 128'(a_full), 0);
    check("mixed.empty", 128'(a_empty), 0);

    // Asynchronous reset in the middle of shifting.
    repeat (3) begin
      set_op(0, 2'd1);
      set_op(1, 2'd1);
      tick();
    end
    assert_reset();
    set_op(0, 2'd1);
    set_op(1, 2'd1);
    tick();
    clr_n = 1'b1;

    // 32 right pushes on the 16-stage instance; the first 16 emerge in order.
    for (int i = 0; i < 32; i++) begin
      set_idle(0);
      set_op(1, 2'd1);
      tick();
      if (i == 15) check("b.full_after_16", 128'(b_full), 1);
    end

    // Random soak on both instances.
    repeat (400) begin
      rand_in(0);
      rand_in(1);
      tick();
    end

    check("drain.eq", 128'(eq0.size() + eq1.size()), 0);
    check("drain.ser", 128'(sq0.size() + sq1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
